// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and defaults for the frequency meter back end.
//   state_t         - measurement FSM states (IDLE, CLEAR, COUNT, LATCH)
//   bcd_digit_t     - one 4-bit BCD decade
//   DIGITS_DEF      - default number of decades
//   SYNC_STAGES_DEF - default synchroniser depth
package freq_meter_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, COUNT, LATCH} state_t;
   typedef logic [3:0] bcd_digit_t;
   localparam int DIGITS_DEF = 8;
   localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/freq_count_latch_bcd_decade.sv
// bcd_decade: one BCD decade of the measurement counter.
//   clk, rst - system clock, synchronous active-high reset
//   inc      - add one to this decade
//   clr      - force the decade to 0 (wins over inc)
//   carry    - inc while the decade holds 9; feeds the next decade this cycle
//   digit    - current decade value
module bcd_decade
   import freq_meter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic       carry,
   output bcd_digit_t digit
);
   bcd_digit_t digit_q, digit_d;
   always_comb digit_d = clr ? 4'd0 : !inc ? digit_q : (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
   always_ff @(posedge clk) digit_q <= rst ? 4'd0 : digit_d;
   assign carry = inc & (digit_q == 4'd9);
   assign digit = digit_q;
endmodule

// File: rtl/freq_count_latch.sv
// freq_count_latch: frequency meter back end; counts fx edges during the gate and latches the BCD result.
//   clk, rst     - system clock, synchronous active-high reset
//   fx           - asynchronous signal under measurement (fx < f_clk/4)
//   Counter_EN   - asynchronous gate-open level
//   Latch_EN     - asynchronous latch-phase level
//   Counter_Clr  - asynchronous clear-phase level
//   bcd_out      - latched count, digit 0 in bits [3:0]
//   valid        - one-cycle pulse when bcd_out updates
//   overflow     - overflow flag of the window held in bcd_out
//   busy         - high while counting
// Build option: FREQ_OVF_DETECT_EN saturates the counter at all 9s and reports overflow;
// without it the counter wraps and overflow is tied to 0.
module freq_count_latch
   import freq_meter_pkg::*;
#(
   parameter int DIGITS      = DIGITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fx,
   input  logic                Counter_EN,
   input  logic                Latch_EN,
   input  logic                Counter_Clr,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                valid,
   output logic                overflow,
   output logic                busy
);
   logic [SYNC_STAGES-1:0] fx_sync_q, en_sync_q, lat_sync_q, clr_sync_q;
   logic                   fx_d_q, cap_q, cap_d, valid_q, capture;
   logic                   fx_s, en_s, lat_s, clr_s, fx_rise, cnt_inc, cnt_clr;
   logic [4*DIGITS-1:0]    cnt, bcd_q;
   logic [DIGITS:0]        carry;
   logic                   carry_unused;
   state_t                 state_q, state_d;

   assign fx_s    = fx_sync_q[SYNC_STAGES-1];
   assign en_s    = en_sync_q[SYNC_STAGES-1];
   assign lat_s   = lat_sync_q[SYNC_STAGES-1];
   assign clr_s   = clr_sync_q[SYNC_STAGES-1];
   assign fx_rise = fx_s & ~fx_d_q;
   // Edges seen in the cycle en_s drops are excluded: the gate has already closed.
   assign cnt_inc = (state_q == COUNT) & en_s & fx_rise;
   assign cnt_clr = (state_q == CLEAR);
   assign carry_unused = carry[DIGITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         fx_sync_q  <= '0;
         en_sync_q  <= '0;
         lat_sync_q <= '0;
         clr_sync_q <= '0;
         fx_d_q     <= 1'b0;
         state_q    <= IDLE;
         cap_q      <= 1'b0;
         valid_q    <= 1'b0;
         bcd_q      <= '0;
      end else begin
         fx_sync_q  <= {fx_sync_q[SYNC_STAGES-2:0], fx};
         en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], Counter_EN};
         lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], Latch_EN};
         clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], Counter_Clr};
         fx_d_q     <= fx_s;
         state_q    <= state_d;
         cap_q      <= cap_d;
         valid_q    <= capture;
         bcd_q      <= capture ? cnt : bcd_q;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE:  state_d = clr_s ? CLEAR : IDLE;
         CLEAR: state_d = en_s ? COUNT : CLEAR;
         COUNT: state_d = !en_s ? LATCH : (clr_s | lat_s) ? IDLE : COUNT;
         LATCH: begin
            // cap_q limits each LATCH visit to a single capture.
            capture = lat_s & ~cap_q & ~en_s;
            state_d = en_s ? IDLE : clr_s ? CLEAR : LATCH;
         end
         default: state_d = IDLE;
      endcase
      cap_d = (state_q == LATCH) & (cap_q | capture);
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_dec
      bcd_decade u_dec (
         .clk   (clk),
         .rst   (rst),
         .inc   (carry[i]),
         .clr   (cnt_clr),
         .carry (carry[i+1]),
         .digit (cnt[4*i +: 4])
      );
   end

`ifdef FREQ_OVF_DETECT_EN
   logic all_nine, ovf_cnt_q, ovf_q;
   always_comb begin
      all_nine = 1'b1;
      for (int i = 0; i < DIGITS; i++) all_nine = all_nine & (cnt[4*i +: 4] == 4'd9);
   end
   // Blocking the increment at all 9s keeps the counter saturated.
   assign carry[0] = cnt_inc & ~all_nine;
   always_ff @(posedge clk) begin
      ovf_cnt_q <= (rst | cnt_clr) ? 1'b0 : ovf_cnt_q | (cnt_inc & all_nine);
      ovf_q     <= rst ? 1'b0 : capture ? ovf_cnt_q : ovf_q;
   end
   assign overflow = ovf_q;
`else
   assign carry[0] = cnt_inc;
   assign overflow = 1'b0;
`endif

   assign bcd_out = bcd_q;
   assign valid   = valid_q;
   assign busy    = (state_q == COUNT);
endmodule

// File: tb/tb_freq_count_latch.sv
// tb_freq_count_latch: self-checking bench for freq_count_latch (8-digit and 2-digit instances).
module tb_freq_count_latch;
`ifdef FREQ_OVF_DETECT_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1, fx = 1'b0;
   logic        Counter_EN = 1'b0, Latch_EN = 1'b0, Counter_Clr = 1'b0;
   logic [31:0] bcd_out;
   logic [7:0]  bcd2;
   logic        valid, overflow, busy, valid2, ov2, busy2;
   int          n_cmp = 0, n_err = 0, vcnt = 0;

   always #5 clk = ~clk;

   freq_count_latch #(.DIGITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .fx(fx), .Counter_EN(Counter_EN), .Latch_EN(Latch_EN),
      .Counter_Clr(Counter_Clr), .bcd_out(bcd_out), .valid(valid), .overflow(overflow), .busy(busy)
   );
   freq_count_latch #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .fx(fx), .Counter_EN(Counter_EN), .Latch_EN(Latch_EN),
      .Counter_Clr(Counter_Clr), .bcd_out(bcd2), .valid(valid2), .overflow(ov2), .busy(busy2)
   );

   always @(negedge clk) if (valid) vcnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         fx = 1'b1; cyc(5); fx = 1'b0; cyc(5);
      end
   endtask

   // Latch phase; valid must appear exactly 3 edges after the pin rise, for one cycle.
   task automatic latch(input logic exp_v);
      Latch_EN = 1'b1;
      cyc(2); chk("valid_early", {31'b0, valid}, 32'd0);
      cyc(1); chk("valid_pulse", {30'b0, valid2, valid}, {30'b0, exp_v, exp_v});
      cyc(1); chk("valid_width", {31'b0, valid}, 32'd0);
      cyc(2); Latch_EN = 1'b0; cyc(4);
   endtask

   // mode 1: last fx rise lands with the gate fall; mode 2: one cycle earlier.
   task automatic window(input int n, input int mode);
      Counter_Clr = 1'b1; cyc(6); Counter_Clr = 1'b0; cyc(2);
      Counter_EN = 1'b1; cyc(6);
      chk("busy_count", {31'b0, busy}, 32'd1);
      pulses(n);
      if (mode == 2) begin fx = 1'b1; cyc(1); end
      if (mode == 1) fx = 1'b1;
      Counter_EN = 1'b0; cyc(6); fx = 1'b0; cyc(6);
      latch(1'b1);
   endtask

   typedef struct {
      int          edges;
      logic [31:0] e8;
      logic [7:0]  e2;
      logic        o2;
   } vec_t;
   vec_t vecs[9];

   initial begin
      int v0;
      vecs[0] = '{0,    32'h0000_0000, 8'h00, 1'b0};
      vecs[1] = '{1,    32'h0000_0001, 8'h01, 1'b0};
      vecs[2] = '{9,    32'h0000_0009, 8'h09, 1'b0};
      vecs[3] = '{10,   32'h0000_0010, 8'h10, 1'b0};
      vecs[4] = '{99,   32'h0000_0099, 8'h99, 1'b0};
      vecs[5] = '{100,  32'h0000_0100, OVF ? 8'h99 : 8'h00, OVF};
      vecs[6] = '{105,  32'h0000_0105, OVF ? 8'h99 : 8'h05, OVF};
      vecs[7] = '{1234, 32'h0000_1234, OVF ? 8'h99 : 8'h34, OVF};
      vecs[8] = '{1234, 32'h0000_1234, OVF ? 8'h99 : 8'h34, OVF};

      // Reset with the gate already open: the partial first window must be discarded.
      Counter_EN = 1'b1;
      cyc(3);
      chk("rst_bcd", bcd_out, 32'd0);
      chk("rst_flags", {29'b0, valid, overflow, busy}, 32'd0);
      chk("rst_bcd2", {24'b0, bcd2}, 32'd0);
      rst = 1'b0;
      pulses(20);
      chk("discard_busy", {31'b0, busy}, 32'd0);
      Counter_EN = 1'b0; cyc(6);
      latch(1'b0);
      chk("discard_vcnt", vcnt, 32'd0);

      for (int i = 0; i < 9; i++) begin
         v0 = vcnt;
         window(vecs[i].edges, 0);
         chk("win_vcnt", vcnt - v0, 32'd1);
         chk("win_bcd", bcd_out, vecs[i].e8);
         chk("win_ovf", {31'b0, overflow}, 32'd0);
         chk("win_bcd2", {24'b0, bcd2}, {24'b0, vecs[i].e2});
         chk("win_ovf2", {31'b0, ov2}, {31'b0, vecs[i].o2});
      end

      window(5, 1);
      chk("edge_same_cycle", bcd_out, 32'h5);
      window(5, 2);
      chk("edge_cycle_before", bcd_out, 32'h6);

      // Clear strobe inside the gate: abandon the window, keep the last result.
      v0 = vcnt;
      Counter_Clr = 1'b1; cyc(6); Counter_Clr = 1'b0; cyc(2);
      Counter_EN = 1'b1; cyc(6);
      pulses(3);
      Counter_Clr = 1'b1; cyc(4);
      chk("viol_busy", {31'b0, busy}, 32'd0);
      Counter_EN = 1'b0; cyc(6); Counter_Clr = 1'b0; cyc(4);
      latch(1'b0);
      chk("viol_vcnt", vcnt - v0, 32'd0);
      chk("viol_bcd", bcd_out, 32'h6);

      // Reset in the middle of counting.
      v0 = vcnt;
      Counter_Clr = 1'b1; cyc(6); Counter_Clr = 1'b0; cyc(2);
      Counter_EN = 1'b1; cyc(6);
      pulses(7);
      rst = 1'b1; cyc(3); rst = 1'b0;
      chk("midrst_bcd", bcd_out, 32'd0);
      chk("midrst_flags", {29'b0, valid, overflow, busy}, 32'd0);
      pulses(2);
      Counter_EN = 1'b0; cyc(6);
      latch(1'b0);
      chk("midrst_vcnt", vcnt - v0, 32'd0);
      window(3, 0);
      chk("midrst_next_bcd", bcd_out, 32'h3);
      chk("midrst_next_vcnt", vcnt - v0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
